nl2_cln_mst_wrsp_return: RTL and testbench
==========================================

Name: nl2_cln_mst_wrsp_return

Overview:
- Returns master-port write responses to the TXC that issued the write.
- At write dispatch, a TXC records an entry mapping master write id to TXC index, plus a 4kB-split flag.
- Each IBP write response from the master port is looked up by id. Split writes merge two responses into one.
- The result is delivered as a one-cycle mst_wr_done pulse with mst_wr_done_wrsp / mst_wr_done_id into the TXC state.

Parameters:
NUM_TXC, 8, number of transaction controllers; TXC index width TXC_W = $clog2(NUM_TXC)
MST_ADR, 4, master write id width; NUM_IDS = 2**MST_ADR entries
WRSP_W, 2, write response width; bit0 = error, bit1 = exclusive-okay
TIMEOUT_W, 10, watchdog counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  TXC registers an outstanding master write
alloc_txc  in  TXC_W  issuing TXC index
alloc_id  in  MST_ADR  master write id (mst_dispatched_id)
alloc_split  in  1  write crosses 4kB; two responses expected (mst_wr_issued_xboundary)
alloc_ready  out  1  entry[alloc_id] is idle; allocation taken on alloc_valid & alloc_ready
wrsp_valid  in  1  master write response valid
wrsp_accept  out  1  response accepted
wrsp_id  in  MST_ADR  response id
wrsp_resp  in  WRSP_W  response code
mst_wr_done  out  NUM_TXC  one-hot completion pulse
mst_wr_done_wrsp  out  WRSP_W  merged response
mst_wr_done_id  out  MST_ADR  id of completed write
err_unexp  out  1  pulse: response for an idle entry
outstanding  out  NUM_IDS  per-id busy vector (entry state != E_IDLE)

Behaviour:
- Reset values: all entries E_IDLE; mst_wr_done = 0; mst_wr_done_wrsp = 0; mst_wr_done_id = 0; err_unexp = 0; wrsp_accept = 0.
- wrsp_accept is a register set to 1 on the first clock after reset release and held at 1. There is no downstream backpressure.
- Per-entry state machine, states E_IDLE, E_WAIT_FIRST, E_WAIT_LAST; each entry stores txc and acc_resp.
  - E_IDLE, on alloc: go to E_WAIT_FIRST if alloc_split, else E_WAIT_LAST; txc <- alloc_txc; acc_resp <- 2'b10 (error=0, exclusive-okay=1).
  - E_WAIT_FIRST, on response: acc_resp <- {acc[1] & resp[1], acc[0] | resp[0]}; go to E_WAIT_LAST; no delivery.
  - E_WAIT_LAST, on response: deliver merged {acc[1] & resp[1], acc[0] | resp[0]}; go to E_IDLE.
- Latency: a response accepted in cycle N produces mst_wr_done[txc] = 1 in cycle N+1 for exactly one cycle, with wrsp/id valid in that cycle. Outputs are registered; wrsp/id hold their last value when no pulse.
- alloc_ready is combinational from registered state: entry[alloc_id] == E_IDLE. An entry freed in cycle N can be reallocated from cycle N+1.
- Simultaneous alloc and response in the same cycle with different ids: both processed.
- Simultaneous alloc and response with the same id: only possible when the entry is idle. The response is treated as unexpected and the alloc is taken.
- Unexpected response (entry E_IDLE): accepted and dropped; err_unexp = 1 in N+1; no mst_wr_done.
- At most one mst_wr_done bit is set per cycle.
- rst_n assertion mid-operation: all entries forced idle immediately. Outstanding writes are not delivered; the TXCs are reset concurrently.

Optional Feature:
NL2_CLN_WRSP_TIMEOUT_EN
- Defined:
  - Each non-idle entry has a TIMEOUT_W-bit counter, cleared on alloc and on a first-half response, incremented each cycle.
  - At all-ones, the entry delivers mst_wr_done with wrsp = 2'b01 (error) and goes to E_IDLE.
  - A later response for that id follows the unexpected-response path.
  - If a timeout and a real response for different entries complete in the same cycle, the real response is delivered first and the timeout is delayed one cycle.
- Undefined: no counters; entries wait indefinitely.

Test Plan:
- Alloc id=3, txc=5, split=0; response id=3, resp=2'b10 two cycles later -> next cycle mst_wr_done=8'b0010_0000, wrsp=2'b10, id=3; outstanding[3]=0 after.
- Alloc id=7, txc=2, split=1; responses 2'b10 then 2'b01 -> single pulse on bit 2 after second response, wrsp=2'b01; no pulse after first.
- Response id=9 with no alloc -> err_unexp=1 one cycle, mst_wr_done=0; alloc id=9 then accepted normally.
- Alloc id=4, id=4 again while busy -> alloc_ready=0 on second; after completion pulse, alloc_ready=1 next cycle.
- Alloc ids 0..15 to txc i%8, responses in reverse order back-to-back -> 16 pulses, one per cycle, correct txc/id each; rst_n pulled low mid-stream -> outputs 0, outstanding=0.
- With NL2_CLN_WRSP_TIMEOUT_EN, TIMEOUT_W=4: alloc id=1, txc=0, no response -> pulse at 15 cycles after alloc, wrsp=2'b01; late response id=1 -> err_unexp.

Source files
------------

// File: rtl/nl2_cln_mst_wrsp_return.sv
// Routes master-port write responses back to the issuing TXC, merging the two halves of 4kB-split writes.
// Optional watchdog per entry: define NL2_CLN_WRSP_TIMEOUT_EN.
module nl2_cln_mst_wrsp_return #(
  parameter int unsigned NUM_TXC = 8,
  parameter int unsigned MST_ADR = 4,
  parameter int unsigned WRSP_W  = 2
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_W = 10
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_valid,
  input  logic [$clog2(NUM_TXC)-1:0]  alloc_txc,
  input  logic [MST_ADR-1:0]          alloc_id,
  input  logic                        alloc_split,
  output logic                        alloc_ready,
  input  logic                        wrsp_valid,
  output logic                        wrsp_accept,
  input  logic [MST_ADR-1:0]          wrsp_id,
  input  logic [WRSP_W-1:0]           wrsp_resp,
  output logic [NUM_TXC-1:0]          mst_wr_done,
  output logic [WRSP_W-1:0]           mst_wr_done_wrsp,
  output logic [MST_ADR-1:0]          mst_wr_done_id,
  output logic                        err_unexp,
  output logic [(2**MST_ADR)-1:0]     outstanding
);

  localparam int unsigned TXC_W   = $clog2(NUM_TXC);
  localparam int unsigned NUM_IDS = 2**MST_ADR;

  typedef enum logic [1:0] {
    E_IDLE       = 2'd0,
    E_WAIT_FIRST = 2'd1,
    E_WAIT_LAST  = 2'd2
  } ent_state_e;

  ent_state_e        st_q  [NUM_IDS];
  ent_state_e        st_d  [NUM_IDS];
  logic [TXC_W-1:0]  txc_q [NUM_IDS];
  logic [TXC_W-1:0]  txc_d [NUM_IDS];
  logic [WRSP_W-1:0] acc_q [NUM_IDS];
  logic [WRSP_W-1:0] acc_d [NUM_IDS];
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q [NUM_IDS];
  logic [TIMEOUT_W-1:0] cnt_d [NUM_IDS];
`endif

  logic              alloc_fire;
  logic              rsp_fire;
  logic [WRSP_W-1:0] rsp_merged;
  logic              rsp_last_c;
  logic              unexp_c;
  logic              to_valid;
  logic [MST_ADR-1:0] to_sel;
  logic              dlv_c;
  logic [MST_ADR-1:0] dlv_id;
  logic [TXC_W-1:0]  dlv_txc;
  logic [WRSP_W-1:0] dlv_resp;

  // Error is sticky across halves; exclusive-okay only if every half says so.
  function automatic logic [WRSP_W-1:0] merge_resp(input logic [WRSP_W-1:0] acc,
                                                   input logic [WRSP_W-1:0] rsp);
    logic [WRSP_W-1:0] m;
    m    = acc & rsp;
    m[0] = acc[0] | rsp[0];
    return m;
  endfunction

  assign alloc_ready = (st_q[alloc_id] == E_IDLE);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign rsp_fire    = wrsp_valid & wrsp_accept;

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) outstanding[i] = (st_q[i] != E_IDLE);
  end

  // State register for all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        st_q[i]  <= E_IDLE;
        txc_q[i] <= '0;
        acc_q[i] <= '0;
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
        cnt_q[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        st_q[i]  <= st_d[i];
        txc_q[i] <= txc_d[i];
        acc_q[i] <= acc_d[i];
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
    end
  end

  // Output decode: response lookup, timeout arbitration, delivery select
  always_comb begin
    rsp_merged = merge_resp(acc_q[wrsp_id], wrsp_resp);
    rsp_last_c = rsp_fire && (st_q[wrsp_id] == E_WAIT_LAST);
    unexp_c    = rsp_fire && (st_q[wrsp_id] == E_IDLE);
    to_valid   = 1'b0;
    to_sel     = '0;
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (st_q[i] != E_IDLE && cnt_q[i] == '1 &&
          !(rsp_fire && wrsp_id == MST_ADR'(i))) begin
        to_valid = 1'b1;
        to_sel   = MST_ADR'(i);
      end
    end
    // A real completion owns the done port this cycle; the timeout waits.
    if (rsp_last_c) to_valid = 1'b0;
`endif
    dlv_c    = rsp_last_c | to_valid;
    dlv_id   = rsp_last_c ? wrsp_id : to_sel;
    dlv_txc  = txc_q[dlv_id];
    dlv_resp = rsp_last_c ? rsp_merged : WRSP_W'(1);
  end

  // Per-entry next state
  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) begin
      st_d[i]  = st_q[i];
      txc_d[i] = txc_q[i];
      acc_d[i] = acc_q[i];
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
      cnt_d[i] = (st_q[i] != E_IDLE && cnt_q[i] != '1) ? cnt_q[i] + TIMEOUT_W'(1) : cnt_q[i];
`endif
      unique case (st_q[i])
        E_IDLE: begin
          if (alloc_fire && alloc_id == MST_ADR'(i)) begin
            st_d[i]  = alloc_split ? E_WAIT_FIRST : E_WAIT_LAST;
            txc_d[i] = alloc_txc;
            acc_d[i] = WRSP_W'(2);
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
            cnt_d[i] = '0;
`endif
          end
        end
        E_WAIT_FIRST: begin
          if (rsp_fire && wrsp_id == MST_ADR'(i)) begin
            st_d[i]  = E_WAIT_LAST;
            acc_d[i] = rsp_merged;
`ifdef NL2_CLN_WRSP_TIMEOUT_EN
            cnt_d[i] = '0;
`endif
          end else if (to_valid && to_sel == MST_ADR'(i)) begin
            st_d[i] = E_IDLE;
          end
        end
        E_WAIT_LAST: begin
          if (rsp_fire && wrsp_id == MST_ADR'(i)) begin
            st_d[i] = E_IDLE;
          end else if (to_valid && to_sel == MST_ADR'(i)) begin
            st_d[i] = E_IDLE;
          end
        end
        default: st_d[i] = E_IDLE;
      endcase
    end
  end

  // Registered completion and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrsp_accept      <= 1'b0;
      err_unexp        <= 1'b0;
      mst_wr_done      <= '0;
      mst_wr_done_wrsp <= '0;
      mst_wr_done_id   <= '0;
    end else begin
      wrsp_accept <= 1'b1;
      err_unexp   <= unexp_c;
      mst_wr_done <= dlv_c ? (NUM_TXC'(1) << dlv_txc) : '0;
      if (dlv_c) begin
        mst_wr_done_wrsp <= dlv_resp;
        mst_wr_done_id   <= dlv_id;
      end
    end
  end

endmodule

// File: tb/tb_nl2_cln_mst_wrsp_return.sv
// Directed self-checking bench for nl2_cln_mst_wrsp_return.
module tb_nl2_cln_mst_wrsp_return;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [2:0]  alloc_txc;
  logic [3:0]  alloc_id;
  logic        alloc_split;
  logic        alloc_ready;
  logic        wrsp_valid;
  logic        wrsp_accept;
  logic [3:0]  wrsp_id;
  logic [1:0]  wrsp_resp;
  logic [7:0]  mst_wr_done;
  logic [1:0]  mst_wr_done_wrsp;
  logic [3:0]  mst_wr_done_id;
  logic        err_unexp;
  logic [15:0] outstanding;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef NL2_CLN_WRSP_TIMEOUT_EN
  nl2_cln_mst_wrsp_return #(.NUM_TXC(8), .MST_ADR(4), .WRSP_W(2), .TIMEOUT_W(4)) dut (
`else
  nl2_cln_mst_wrsp_return #(.NUM_TXC(8), .MST_ADR(4), .WRSP_W(2)) dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_txc(alloc_txc), .alloc_id(alloc_id),
    .alloc_split(alloc_split), .alloc_ready(alloc_ready),
    .wrsp_valid(wrsp_valid), .wrsp_accept(wrsp_accept), .wrsp_id(wrsp_id),
    .wrsp_resp(wrsp_resp), .mst_wr_done(mst_wr_done),
    .mst_wr_done_wrsp(mst_wr_done_wrsp), .mst_wr_done_id(mst_wr_done_id),
    .err_unexp(err_unexp), .outstanding(outstanding)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input logic [3:0] id, input logic [2:0] txc, input logic split);
    alloc_valid = 1'b1; alloc_id = id; alloc_txc = txc; alloc_split = split;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_rsp(input logic [3:0] id, input logic [1:0] resp);
    wrsp_valid = 1'b1; wrsp_id = id; wrsp_resp = resp;
    tick();
    wrsp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_txc = '0; alloc_id = '0; alloc_split = 1'b0;
    wrsp_valid = 1'b0; wrsp_id = '0; wrsp_resp = '0;
    tick(); tick();
    chk("rst_done", 32'(mst_wr_done), 32'h0);
    chk("rst_accept", 32'(wrsp_accept), 32'h0);
    chk("rst_err", 32'(err_unexp), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_wrsp_id", 32'({mst_wr_done_wrsp, mst_wr_done_id}), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("accept_after_rst", 32'(wrsp_accept), 32'h1);

    // Simple non-split write
    alloc_id = 4'd3;
    chk("t1_ready", 32'(alloc_ready), 32'h1);
    do_alloc(4'd3, 3'd5, 1'b0);
    chk("t1_outst", 32'(outstanding), 32'h0008);
    tick();
    do_rsp(4'd3, 2'b10);
    chk("t1_done", 32'(mst_wr_done), 32'h20);
    chk("t1_wrsp", 32'(mst_wr_done_wrsp), 32'h2);
    chk("t1_id", 32'(mst_wr_done_id), 32'h3);
    chk("t1_outst_after", 32'(outstanding), 32'h0);
    tick();
    chk("t1_pulse_end", 32'(mst_wr_done), 32'h0);
    chk("t1_wrsp_hold", 32'(mst_wr_done_wrsp), 32'h2);

    // Split write: two responses merge into one
    do_alloc(4'd7, 3'd2, 1'b1);
    do_rsp(4'd7, 2'b10);
    chk("t2_no_first", 32'(mst_wr_done), 32'h0);
    chk("t2_outst", 32'(outstanding), 32'h0080);
    do_rsp(4'd7, 2'b01);
    chk("t2_done", 32'(mst_wr_done), 32'h04);
    chk("t2_wrsp", 32'(mst_wr_done_wrsp), 32'h1);
    chk("t2_id", 32'(mst_wr_done_id), 32'h7);
    tick();
    chk("t2_pulse_end", 32'(mst_wr_done), 32'h0);

    // Split with both halves exclusive-okay
    do_alloc(4'd2, 3'd3, 1'b1);
    do_rsp(4'd2, 2'b10);
    do_rsp(4'd2, 2'b10);
    chk("t2b_done", 32'(mst_wr_done), 32'h08);
    chk("t2b_wrsp", 32'(mst_wr_done_wrsp), 32'h2);

    // Unexpected response, then normal use of that id
    do_rsp(4'd9, 2'b00);
    chk("t3_err", 32'(err_unexp), 32'h1);
    chk("t3_nodone", 32'(mst_wr_done), 32'h0);
    tick();
    chk("t3_err_end", 32'(err_unexp), 32'h0);
    do_alloc(4'd9, 3'd1, 1'b0);
    do_rsp(4'd9, 2'b00);
    chk("t3_done", 32'(mst_wr_done), 32'h02);
    chk("t3_wrsp", 32'(mst_wr_done_wrsp), 32'h0);
    chk("t3_id", 32'(mst_wr_done_id), 32'h9);
    chk("t3_err_none", 32'(err_unexp), 32'h0);

    // Busy entry refuses a second alloc
    do_alloc(4'd4, 3'd6, 1'b0);
    alloc_valid = 1'b1; alloc_id = 4'd4; alloc_txc = 3'd3; alloc_split = 1'b0;
    #1;
    chk("t4_busy", 32'(alloc_ready), 32'h0);
    tick();
    alloc_valid = 1'b0;
    do_rsp(4'd4, 2'b11);
    chk("t4_done", 32'(mst_wr_done), 32'h40);
    chk("t4_wrsp", 32'(mst_wr_done_wrsp), 32'h3);
    alloc_id = 4'd4;
    #1;
    chk("t4_ready_again", 32'(alloc_ready), 32'h1);

    // Same-id alloc and response together: response is unexpected, alloc taken
    alloc_valid = 1'b1; alloc_id = 4'd5; alloc_txc = 3'd4; alloc_split = 1'b0;
    wrsp_valid = 1'b1; wrsp_id = 4'd5; wrsp_resp = 2'b01;
    tick();
    alloc_valid = 1'b0; wrsp_valid = 1'b0;
    chk("t5_err", 32'(err_unexp), 32'h1);
    chk("t5_nodone", 32'(mst_wr_done), 32'h0);
    chk("t5_outst", 32'(outstanding), 32'h0020);
    do_rsp(4'd5, 2'b00);
    chk("t5_done", 32'(mst_wr_done), 32'h10);

    // Different-id alloc and response together: both processed
    do_alloc(4'd11, 3'd0, 1'b0);
    alloc_valid = 1'b1; alloc_id = 4'd10; alloc_txc = 3'd7; alloc_split = 1'b0;
    wrsp_valid = 1'b1; wrsp_id = 4'd11; wrsp_resp = 2'b10;
    tick();
    alloc_valid = 1'b0; wrsp_valid = 1'b0;
    chk("t6_done", 32'(mst_wr_done), 32'h01);
    chk("t6_id", 32'(mst_wr_done_id), 32'hB);
    chk("t6_outst", 32'(outstanding), 32'h0400);
    do_rsp(4'd10, 2'b00);
    chk("t6_done2", 32'(mst_wr_done), 32'h80);

    // Fill all ids, retire in reverse, back to back
    for (int i = 0; i < 16; i++) do_alloc(4'(i), 3'(i % 8), 1'b0);
    chk("t7_full", 32'(outstanding), 32'hFFFF);
    for (int i = 15; i >= 0; i--) begin
      wrsp_valid = 1'b1; wrsp_id = 4'(i); wrsp_resp = 2'(i % 4);
      tick();
      chk($sformatf("t7_done_%0d", i), 32'(mst_wr_done), 32'(8'h01 << (i % 8)));
      chk($sformatf("t7_id_%0d", i), 32'(mst_wr_done_id), 32'(i));
      chk($sformatf("t7_wrsp_%0d", i), 32'(mst_wr_done_wrsp), 32'(i % 4));
    end
    wrsp_valid = 1'b0;
    chk("t7_empty", 32'(outstanding), 32'h0);

    // Reset asserted mid-stream
    for (int i = 0; i < 16; i++) do_alloc(4'(i), 3'(i % 8), 1'b0);
    do_rsp(4'd15, 2'b10);
    do_rsp(4'd14, 2'b10);
    chk("t8_pre_done", 32'(mst_wr_done), 32'h40);
    rst_n = 1'b0;
    #1;
    chk("t8_done0", 32'(mst_wr_done), 32'h0);
    chk("t8_outst0", 32'(outstanding), 32'h0);
    chk("t8_accept0", 32'(wrsp_accept), 32'h0);
    chk("t8_id0", 32'(mst_wr_done_id), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_rsp(4'd13, 2'b10);
    chk("t8_stale_err", 32'(err_unexp), 32'h1);
    chk("t8_stale_nodone", 32'(mst_wr_done), 32'h0);

`ifdef NL2_CLN_WRSP_TIMEOUT_EN
    begin
      int lat;
      lat = -1;
      do_alloc(4'd1, 3'd0, 1'b0);
      for (int k = 1; k <= 40 && lat < 0; k++) begin
        tick();
        if (mst_wr_done != 8'h0) lat = k;
      end
      chk("to_seen", 32'(lat > 0), 32'h1);
      chk("to_latency", 32'(lat == 15 || lat == 16), 32'h1);
      chk("to_done", 32'(mst_wr_done), 32'h01);
      chk("to_wrsp", 32'(mst_wr_done_wrsp), 32'h1);
      chk("to_id", 32'(mst_wr_done_id), 32'h1);
      tick();
      do_rsp(4'd1, 2'b10);
      chk("to_late_err", 32'(err_unexp), 32'h1);
      chk("to_late_nodone", 32'(mst_wr_done), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
